// File: rtl/klotski_motion_pkg.sv
// Shared types for the tile-move gantry: FSM states, cell encoding, axis directions.
// Optional build macro: MOVE_EXEC_RETURN_HOME_EN adds the S_HOME state.
package klotski_motion_pkg;

  localparam int unsigned CELL_W  = 4;
  localparam logic        DIR_POS = 1'b1;
  localparam logic        DIR_NEG = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRAVEL,
    S_GRAB,
    S_CARRY,
    S_RELEASE,
    S_DONE
`ifdef MOVE_EXEC_RETURN_HOME_EN
    , S_HOME
`endif
  } state_t;

  // Sub-phase of a two-axis move: evaluate deltas, wait X, wait Y
  typedef enum logic [1:0] {
    MP_INIT,
    MP_XWAIT,
    MP_YWAIT
  } mphase_t;

  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } cell_t;

endpackage

// File: rtl/axis_stepper.sv
// Single-axis step pulse generator: latches dir and step count on i_start, then emits
// i_steps pulses (low half-period first, then high), with a 1-cycle o_done at the end.
module axis_stepper #(
  parameter int unsigned HALF_PERIOD = 25000,
  parameter int unsigned CNT_W       = 24
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_dir,
  input  logic [CNT_W-1:0] i_steps,
  output logic             o_step,
  output logic             o_dir,
  output logic             o_done
);

  logic             r_active;
  logic             r_step;
  logic             r_dir;
  logic             r_done;
  logic [CNT_W-1:0] r_half_cnt;
  logic [CNT_W-1:0] r_step_cnt;
  logic             w_half_end;

  assign w_half_end = (r_half_cnt == CNT_W'(HALF_PERIOD - 1));

  // Half-period timer and remaining-step counter; step drops together with done
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_active   <= 1'b0;
      r_step     <= 1'b0;
      r_dir      <= 1'b0;
      r_done     <= 1'b0;
      r_half_cnt <= '0;
      r_step_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      if (!r_active) begin
        if (i_start) begin
          r_dir      <= i_dir;
          r_step_cnt <= i_steps;
          r_half_cnt <= '0;
          r_step     <= 1'b0;
          if (i_steps == '0) begin
            r_done <= 1'b1;
          end else begin
            r_active <= 1'b1;
          end
        end
      end else if (w_half_end) begin
        r_half_cnt <= '0;
        if (!r_step) begin
          r_step <= 1'b1;
        end else begin
          r_step     <= 1'b0;
          r_step_cnt <= r_step_cnt - CNT_W'(1);
          if (r_step_cnt == CNT_W'(1)) begin
            r_active <= 1'b0;
            r_done   <= 1'b1;
          end
        end
      end else begin
        r_half_cnt <= r_half_cnt + CNT_W'(1);
      end
    end
  end

  assign o_step = r_step;
  assign o_dir  = r_dir;
  assign o_done = r_done;

endmodule

// File: rtl/move_executor.sv
// Tile-move executor: travels the head to the start cell, grabs the tile with the magnet,
// carries it to the end cell along an X-then-Y path, releases, and pulses o_continue.
// Optional build macro: MOVE_EXEC_RETURN_HOME_EN returns the empty head to cell 0 before done.
module move_executor
  import klotski_motion_pkg::*;
#(
  parameter int unsigned STEPS_PER_CELL   = 400,
  parameter int unsigned STEP_HALF_PERIOD = 25000,
  parameter int unsigned SETTLE_CYCLES    = 5000000,
  parameter int unsigned CNT_W            = 24
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic [CELL_W-1:0] i_start_block,
  input  logic [CELL_W-1:0] i_end_block,
  output logic              o_continue,
  output logic              o_busy,
  output logic              o_step_x,
  output logic              o_dir_x,
  output logic              o_step_y,
  output logic              o_dir_y,
  output logic              o_magnet,
  output logic [CELL_W-1:0] o_head_pos
);

  state_t           r_state;
  state_t           w_next_state;
  mphase_t          r_mphase;
  mphase_t          w_next_mphase;
  cell_t            r_head;
  cell_t            r_start;
  cell_t            r_end;
  cell_t            w_target;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_continue;
  logic             r_magnet;

  logic             w_in_motion;
  logic             w_move_fin;
  logic             w_settled;
  logic             w_x_start;
  logic             w_y_start;
  logic             w_x_done;
  logic             w_y_done;
  logic signed [2:0] w_dx;
  logic signed [2:0] w_dy;
  logic [1:0]       w_dx_mag;
  logic [1:0]       w_dy_mag;
  logic [CNT_W-1:0] w_x_steps;
  logic [CNT_W-1:0] w_y_steps;
  logic             w_x_dir;
  logic             w_y_dir;

  // Signed per-axis displacement from the head to the current motion target
  assign w_dx      = $signed({1'b0, w_target.col}) - $signed({1'b0, r_head.col});
  assign w_dy      = $signed({1'b0, w_target.row}) - $signed({1'b0, r_head.row});
  assign w_dx_mag  = w_dx[2] ? 2'(-w_dx) : 2'(w_dx);
  assign w_dy_mag  = w_dy[2] ? 2'(-w_dy) : 2'(w_dy);
  assign w_x_steps = CNT_W'(w_dx_mag) * CNT_W'(STEPS_PER_CELL);
  assign w_y_steps = CNT_W'(w_dy_mag) * CNT_W'(STEPS_PER_CELL);
  assign w_x_dir   = w_dx[2] ? DIR_NEG : DIR_POS;
  assign w_y_dir   = w_dy[2] ? DIR_NEG : DIR_POS;
  assign w_settled = (r_cnt == CNT_W'(SETTLE_CYCLES - 1));

  // Motion target per state and the X-then-Y sequencer shared by all motion states
  always_comb begin
    w_target      = cell_t'(CELL_W'(0));
    w_in_motion   = 1'b0;
    w_next_mphase = r_mphase;
    w_x_start     = 1'b0;
    w_y_start     = 1'b0;
    w_move_fin    = 1'b0;

    case (r_state)
      S_TRAVEL: begin w_target = r_start; w_in_motion = 1'b1; end
      S_CARRY:  begin w_target = r_end;   w_in_motion = 1'b1; end
`ifdef MOVE_EXEC_RETURN_HOME_EN
      S_HOME:   begin w_target = cell_t'(CELL_W'(0)); w_in_motion = 1'b1; end
`endif
      default:  ;
    endcase

    if (w_in_motion) begin
      case (r_mphase)
        MP_INIT: begin
          if (w_dx != 3'sd0) begin
            w_x_start     = 1'b1;
            w_next_mphase = MP_XWAIT;
          end else if (w_dy != 3'sd0) begin
            w_y_start     = 1'b1;
            w_next_mphase = MP_YWAIT;
          end else begin
            w_move_fin = 1'b1;
          end
        end
        MP_XWAIT: begin
          if (w_x_done) begin
            if (w_dy != 3'sd0) begin
              w_y_start     = 1'b1;
              w_next_mphase = MP_YWAIT;
            end else begin
              w_move_fin = 1'b1;
            end
          end
        end
        MP_YWAIT: begin
          if (w_y_done) begin
            w_move_fin = 1'b1;
          end
        end
        default: w_next_mphase = MP_INIT;
      endcase
      if (w_move_fin) begin
        w_next_mphase = MP_INIT;
      end
    end
  end

  // Next-state logic of the move FSM
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_en) begin
          w_next_state = (i_start_block == i_end_block) ? S_DONE : S_TRAVEL;
        end
      end
      S_TRAVEL:  if (w_move_fin) w_next_state = S_GRAB;
      S_GRAB:    if (w_settled)  w_next_state = S_CARRY;
      S_CARRY:   if (w_move_fin) w_next_state = S_RELEASE;
`ifdef MOVE_EXEC_RETURN_HOME_EN
      S_RELEASE: if (w_settled)  w_next_state = S_HOME;
      S_HOME:    if (w_move_fin) w_next_state = S_DONE;
`else
      S_RELEASE: if (w_settled)  w_next_state = S_DONE;
`endif
      S_DONE:    w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // State, settle counter, head position, latched cells and registered outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_mphase   <= MP_INIT;
      r_cnt      <= '0;
      r_head     <= cell_t'(CELL_W'(0));
      r_start    <= cell_t'(CELL_W'(0));
      r_end      <= cell_t'(CELL_W'(0));
      r_busy     <= 1'b0;
      r_continue <= 1'b0;
      r_magnet   <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_mphase <= w_next_mphase;
      if ((r_state == S_GRAB || r_state == S_RELEASE) && w_next_state == r_state) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end
      if (r_state == S_IDLE && i_en) begin
        r_start <= cell_t'(i_start_block);
        r_end   <= cell_t'(i_end_block);
      end
      if (r_mphase == MP_XWAIT && w_x_done) begin
        r_head.col <= w_target.col;
      end
      if (r_mphase == MP_YWAIT && w_y_done) begin
        r_head.row <= w_target.row;
      end
      r_busy     <= (w_next_state != S_IDLE) || (r_state == S_DONE);
      r_continue <= (r_state == S_DONE);
      r_magnet   <= (r_state == S_GRAB) || (r_state == S_CARRY);
    end
  end

  axis_stepper #(
    .HALF_PERIOD(STEP_HALF_PERIOD),
    .CNT_W      (CNT_W)
  ) u_axis_x (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_start(w_x_start),
    .i_dir  (w_x_dir),
    .i_steps(w_x_steps),
    .o_step (o_step_x),
    .o_dir  (o_dir_x),
    .o_done (w_x_done)
  );

  axis_stepper #(
    .HALF_PERIOD(STEP_HALF_PERIOD),
    .CNT_W      (CNT_W)
  ) u_axis_y (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_start(w_y_start),
    .i_dir  (w_y_dir),
    .i_steps(w_y_steps),
    .o_step (o_step_y),
    .o_dir  (o_dir_y),
    .o_done (w_y_done)
  );

  assign o_busy     = r_busy;
  assign o_continue = r_continue;
  assign o_magnet   = r_magnet;
  assign o_head_pos = r_head;

endmodule
